// File: rtl/phase_step_filter_if.sv
// Bundle between the phase detector / clock mux and the phase step filter.
// master: drives the early/late flags and observes the phase pointer.
// slave : the filter itself.
interface phase_step_filter_if;
  logic        shift_right;
  logic        shift_left;
  logic [3:0]  phase_sel;
  logic [15:0] phase_onehot;
  logic        step_right;
  logic        step_left;
  logic        locked;

  modport master (
    output shift_right, shift_left,
    input  phase_sel, phase_onehot, step_right, step_left, locked
  );

  modport slave (
    input  shift_right, shift_left,
    output phase_sel, phase_onehot, step_right, step_left, locked
  );
endinterface

// File: rtl/phase_step_filter.sv
// Loop filter / phase picker behind the 16-phase oversampling detector.
// Early/late flags are synchronised, turned into +1/-1/0 votes and summed in
// a signed accumulator; reaching +/-THRESH moves the 4-bit phase pointer one
// step and opens a HOLDOFF-cycle window that lets the clock mux settle.
// Optional macro PHASE_LOCK_DETECT_EN adds a step-free-cycle lock detector;
// without it locked is tied low.

// Two-flop synchroniser for one asynchronous detector flag.
module phase_step_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic meta_q, sync_q;

  // Plain double-flop; reset clears both stages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

module phase_step_filter #(
  parameter int THRESH   = 8,
  parameter int ACC_W    = 5,
  parameter int HOLDOFF  = 4,
  parameter int LOCK_CNT = 64
) (
  input  logic               clk,
  input  logic               rst,
  phase_step_filter_if.slave pif
);
  localparam int NUM_FLAGS = 2;
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(THRESH - 1);
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(-(THRESH - 1));
  localparam logic [7:0]              HOLD_LD = 8'(HOLDOFF - 1);

  typedef enum logic {TRACK = 1'b0, HOLD = 1'b1} state_t;

  // Flag synchronisers: bit 0 = shift_right, bit 1 = shift_left.
  logic [NUM_FLAGS-1:0] flag_raw, flag_s;
  assign flag_raw = {pif.shift_left, pif.shift_right};

  for (genvar g = 0; g < NUM_FLAGS; g++) begin : g_sync
    phase_step_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (flag_raw[g]),
      .q_o (flag_s[g])
    );
  end

  // Simultaneous flags carry no timing information, so they cast no vote.
  logic vote_up, vote_dn;
  assign vote_up = flag_s[0] & ~flag_s[1];
  assign vote_dn = flag_s[1] & ~flag_s[0];

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [7:0]               hcnt_q, hcnt_d;
  logic [3:0]               phase_q, phase_d;
  logic [15:0]              onehot_q, onehot_d;
  logic                     step_r_q, step_r_d;
  logic                     step_l_q, step_l_d;

  // Next-state: vote accumulation, pointer stepping and hold-off dwell.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    hcnt_d   = hcnt_q;
    phase_d  = phase_q;
    step_r_d = 1'b0;
    step_l_d = 1'b0;
    case (state_q)
      TRACK: begin
        if (vote_up && acc_q == ACC_MAX) begin
          phase_d  = phase_q + 4'd1;   // 15 wraps to 0
          step_r_d = 1'b1;
          acc_d    = '0;
          hcnt_d   = HOLD_LD;
          state_d  = HOLD;
        end else if (vote_dn && acc_q == ACC_MIN) begin
          phase_d  = phase_q - 4'd1;   // 0 wraps to 15
          step_l_d = 1'b1;
          acc_d    = '0;
          hcnt_d   = HOLD_LD;
          state_d  = HOLD;
        end else if (vote_up) begin
          acc_d = acc_q + ACC_W'(1);
        end else if (vote_dn) begin
          acc_d = acc_q - ACC_W'(1);
        end
      end
      HOLD: begin
        // Votes are ignored while the mux settles; dwell is HOLDOFF edges.
        acc_d = '0;
        if (hcnt_q == 8'd0) state_d = TRACK;
        else                hcnt_d  = hcnt_q - 8'd1;
      end
      default: state_d = TRACK;
    endcase
    onehot_d = 16'h0001 << phase_d;
  end

  // Filter state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= TRACK;
      acc_q    <= '0;
      hcnt_q   <= '0;
      phase_q  <= '0;
      onehot_q <= 16'h0001;
      step_r_q <= 1'b0;
      step_l_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      hcnt_q   <= hcnt_d;
      phase_q  <= phase_d;
      onehot_q <= onehot_d;
      step_r_q <= step_r_d;
      step_l_q <= step_l_d;
    end
  end

  assign pif.phase_sel    = phase_q;
  assign pif.phase_onehot = onehot_q;
  assign pif.step_right   = step_r_q;
  assign pif.step_left    = step_l_q;

`ifdef PHASE_LOCK_DETECT_EN
  localparam logic [15:0] LOCK_MAX = 16'(LOCK_CNT);

  logic [15:0] lcnt_q, lcnt_d;

  // Count step-free TRACK cycles; any step or HOLD cycle restarts the count.
  always_comb begin
    lcnt_d = lcnt_q;
    if (step_r_d || step_l_d || state_q == HOLD) lcnt_d = '0;
    else if (lcnt_q != LOCK_MAX)                 lcnt_d = lcnt_q + 16'd1;
  end

  // Lock counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lcnt_q <= '0;
    else      lcnt_q <= lcnt_d;
  end

  assign pif.locked = (lcnt_q == LOCK_MAX);
`else
  logic unused_lock_cfg;
  assign unused_lock_cfg = (LOCK_CNT != 0);
  assign pif.locked      = 1'b0;
`endif
endmodule

// File: tb/tb_phase_step_filter.sv
// Scoreboard bench for phase_step_filter (THRESH=8, HOLDOFF=4, LOCK_CNT=64).
// Stimulus pushes the expected step events; a negedge monitor pops one entry
// per observed step pulse. Edge numbers count posedges after reset release.
module tb_phase_step_filter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  phase_step_filter_if pif ();

  phase_step_filter #(.THRESH(8), .ACC_W(5), .HOLDOFF(4), .LOCK_CNT(64)) dut (
    .clk (clk),
    .rst (rst),
    .pif (pif)
  );

`ifdef PHASE_LOCK_DETECT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  typedef struct {
    int          edge_no;
    bit          right;
    logic [3:0]  ps;
    logic [15:0] oh;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;
  int   edge_n   = 0;

  always @(posedge clk or negedge rst)
    if (!rst) edge_n <= 0;
    else      edge_n <= edge_n + 1;

  // Monitor: every step pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && (pif.step_right || pif.step_left)) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_step edge=%0d got sr=%0b sl=%0b ps=%0d oh=%h, expected no step",
                 edge_n, pif.step_right, pif.step_left, pif.phase_sel, pif.phase_onehot);
      end else begin
        e = sb.pop_front();
        if (edge_n != e.edge_no || pif.step_right !== e.right || pif.step_left !== !e.right ||
            pif.phase_sel !== e.ps || pif.phase_onehot !== e.oh) begin
          failures++;
          $display("FAIL step edge=%0d sr=%0b sl=%0b ps=%0d oh=%h, expected edge=%0d right=%0b ps=%0d oh=%h",
                   edge_n, pif.step_right, pif.step_left, pif.phase_sel, pif.phase_onehot,
                   e.edge_no, e.right, e.ps, e.oh);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic push(input int edge_no, input bit right, input int ps);
    exp_t x;
    x.edge_no = edge_no;
    x.right   = right;
    x.ps      = 4'(ps);
    x.oh      = 16'h0001 << x.ps;
    sb.push_back(x);
  endtask

  task automatic end_test(input string name);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_steps got pending=%0d expected=0", name, sb.size());
    end
    sb.delete();
  endtask

  task automatic wait_edge(input int n);
    while (edge_n < n) @(negedge clk);
  endtask

  // Reset with the given flags already applied, check reset outputs, release
  // on a negedge so the next posedge is edge 1.
  task automatic do_reset(input bit sr, input bit sl);
    @(negedge clk);
    rst = 1'b0;
    pif.shift_right = sr;
    pif.shift_left  = sl;
    @(negedge clk);
    chk("reset_outputs", {pif.phase_sel, pif.phase_onehot, pif.step_right, pif.step_left, pif.locked},
        {4'd0, 16'h0001, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    pif.shift_right = 1'b0;
    pif.shift_left  = 1'b0;

    // Right flag held: steps every 12 edges from edge 10, full wrap 15->0.
    do_reset(1'b1, 1'b0);
    for (int k = 1; k <= 16; k++) push(10 + 12 * (k - 1), 1'b1, k % 16);
    wait_edge(192);
    end_test("right_sweep");

    // Left flag held: wrap-down 0->15 on edge 10.
    do_reset(1'b0, 1'b1);
    push(10, 1'b0, 15);
    wait_edge(12);
    end_test("left_wrap");

    // Both flags: no votes, no steps.
    do_reset(1'b1, 1'b1);
    wait_edge(100);
    chk("both_flags_ps", pif.phase_sel, 4'd0);
    end_test("both_flags");

    // 5 right, 3 left, 6 right votes: acc 5 -> 2 -> step on the 6th right vote (edge 16).
    do_reset(1'b1, 1'b0);
    push(16, 1'b1, 1);
    for (int c = 1; c <= 14; c++) begin
      pif.shift_right = (c <= 5) || (c >= 9);
      pif.shift_left  = (c >= 6) && (c <= 8);
      @(negedge clk);
    end
    pif.shift_right = 1'b0;
    pif.shift_left  = 1'b0;
    wait_edge(15);
    chk("mixed_pre_step_ps", pif.phase_sel, 4'd0);
    wait_edge(26);
    end_test("mixed_votes");

    // Lock detect: rises at edge 64, falls on the step edge (74).
    do_reset(1'b0, 1'b0);
    wait_edge(63);
    chk("lock_pre", pif.locked, 1'b0);
    wait_edge(64);
    chk("lock_rise", pif.locked, LOCK_EN);
    pif.shift_right = 1'b1;
    push(74, 1'b1, 1);
    wait_edge(73);
    chk("lock_hold", pif.locked, LOCK_EN);
    wait_edge(74);
    chk("lock_fall", pif.locked, 1'b0);
    pif.shift_right = 1'b0;
    wait_edge(80);
    end_test("lock");

    // Reset during HOLD: outputs clear before the next edge, then restart cleanly.
    do_reset(1'b1, 1'b0);
    push(10, 1'b1, 1);
    wait_edge(11);
    chk("hold_ps", pif.phase_sel, 4'd1);
    end_test("pre_hold_reset");
    #1 rst = 1'b0;
    #2;
    chk("hold_reset_outputs", {pif.phase_sel, pif.phase_onehot, pif.step_right, pif.step_left, pif.locked},
        {4'd0, 16'h0001, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b1;
    push(10, 1'b1, 1);
    wait_edge(12);
    end_test("after_hold_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
